// File: rtl/ili9341_cmd_sequencer.sv
// rtl/ili9341_cmd_sequencer.sv - ILI9341 byte-stream FIFO to Wishbone SPI-master sequencer with RESX timing
// Optional: ILI_SEQ_BYTE_COUNT_EN adds the bytes_sent counter port.
module ili9341_cmd_sequencer #(
    parameter int FIFO_DEPTH      = 8,
    parameter int CS_INDEX        = 0,
    parameter int RST_LOW_CYCLES  = 16,
    parameter int RST_WAIT_CYCLES = 64
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        soft_reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_dc,
    input  logic        in_last,
    output logic        STB_O,
    output logic        WE_O,
    output logic [7:0]  ADR_O,
    output logic [7:0]  DAT_O,
    input  logic        ACK_I,
    input  logic        RTY_I,
    output logic        dcx,
    output logic        lcd_resetn,
    output logic        busy
`ifdef ILI_SEQ_BYTE_COUNT_EN
    ,
    output logic [15:0] bytes_sent
`endif
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_MAX = (RST_LOW_CYCLES > RST_WAIT_CYCLES)
                           ? ((RST_LOW_CYCLES > 4) ? RST_LOW_CYCLES : 4)
                           : ((RST_WAIT_CYCLES > 4) ? RST_WAIT_CYCLES : 4);
    localparam int TMR_W   = $clog2(CNT_MAX + 1);

    localparam logic [TMR_W-1:0] LOW_LAST   = TMR_W'(RST_LOW_CYCLES - 1);
    localparam logic [TMR_W-1:0] WAIT_LAST  = TMR_W'(RST_WAIT_CYCLES - 1);
    localparam logic [TMR_W-1:0] GUARD_LAST = TMR_W'(3);
    localparam logic [6:0]       CS_ADR     = 7'(CS_INDEX);
    localparam logic [PTR_W:0]   FULL_CNT   = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_RST_LOW,
        S_RST_WAIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_IDLE
    } state_t;

    state_t             state;
    logic [TMR_W-1:0]   tmr;
    logic               pending;

    logic [9:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               rst_seq_start;
    logic               in_rst_phase;
    logic [9:0]         head;

    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign in_rst_phase = (state == S_RST_LOW) || (state == S_RST_WAIT);
    assign in_ready     = !full && !in_rst_phase;
    assign busy         = !((state == S_IDLE) && empty);
    assign head         = mem[rd_ptr];

    // Entering RST_LOW always flushes the FIFO, including bytes accepted while a reset was pending.
    assign rst_seq_start = (soft_reset && (in_rst_phase || (state == S_IDLE)))
                         || ((state == S_WAIT_IDLE) && !RTY_I && (pending || soft_reset));

    assign push = in_valid && in_ready && !rst_seq_start;
    assign pop  = (state == S_IDLE) && !empty && !soft_reset && !RTY_I;

    always_ff @(posedge CLK_I) begin
        if (push) begin
            mem[wr_ptr] <= {in_last, in_dc, in_data};
        end
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (rst_seq_start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state      <= S_RST_LOW;
            tmr        <= '0;
            pending    <= 1'b0;
            STB_O      <= 1'b0;
            WE_O       <= 1'b0;
            ADR_O      <= 8'h00;
            DAT_O      <= 8'h00;
            dcx        <= 1'b1;
            lcd_resetn <= 1'b0;
        end else if (rst_seq_start) begin
            state      <= S_RST_LOW;
            tmr        <= '0;
            pending    <= 1'b0;
            lcd_resetn <= 1'b0;
        end else begin
            case (state)
                S_RST_LOW: begin
                    if (tmr == LOW_LAST) begin
                        tmr        <= '0;
                        lcd_resetn <= 1'b1;
                        state      <= S_RST_WAIT;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                S_RST_WAIT: begin
                    if (tmr == WAIT_LAST) begin
                        tmr   <= '0;
                        state <= S_IDLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                S_IDLE: begin
                    // dcx is only updated here so it never moves during an SPI byte.
                    if (pop) begin
                        dcx   <= head[8];
                        DAT_O <= head[7:0];
                        ADR_O <= {~head[9], CS_ADR};
                        STB_O <= 1'b1;
                        WE_O  <= 1'b1;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (soft_reset) pending <= 1'b1;
                    if (ACK_I) begin
                        STB_O <= 1'b0;
                        WE_O  <= 1'b0;
                        tmr   <= '0;
                        state <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (soft_reset) pending <= 1'b1;
                    // The SPI master may finish before we ever see RTY_I; don't wait forever.
                    if (RTY_I || (tmr == GUARD_LAST)) begin
                        tmr   <= '0;
                        state <= S_WAIT_IDLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (!RTY_I) begin
                        state <= S_IDLE;
                    end else if (soft_reset) begin
                        pending <= 1'b1;
                    end
                end
                default: begin
                    state <= S_RST_LOW;
                    tmr   <= '0;
                end
            endcase
        end
    end

`ifdef ILI_SEQ_BYTE_COUNT_EN
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            bytes_sent <= 16'h0000;
        end else if (rst_seq_start) begin
            bytes_sent <= 16'h0000;
        end else if ((state == S_ISSUE) && ACK_I) begin
            bytes_sent <= bytes_sent + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_ili9341_cmd_sequencer.sv
// tb/tb_ili9341_cmd_sequencer.sv - scoreboard bench for ili9341_cmd_sequencer with a Wishbone/SPI slave model
module tb_ili9341_cmd_sequencer;

    logic       CLK_I = 1'b0;
    logic       RST_I;
    logic       soft_reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_dc;
    logic       in_last;
    logic       STB_O;
    logic       WE_O;
    logic [7:0] ADR_O;
    logic [7:0] DAT_O;
    logic       ACK_I;
    logic       RTY_I;
    logic       dcx;
    logic       lcd_resetn;
    logic       busy;
`ifdef ILI_SEQ_BYTE_COUNT_EN
    logic [15:0] bytes_sent;
`endif

    always #5 CLK_I = ~CLK_I;

    ili9341_cmd_sequencer dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .soft_reset(soft_reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_dc(in_dc), .in_last(in_last),
        .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O),
        .ACK_I(ACK_I), .RTY_I(RTY_I), .dcx(dcx), .lcd_resetn(lcd_resetn), .busy(busy)
`ifdef ILI_SEQ_BYTE_COUNT_EN
        , .bytes_sent(bytes_sent)
`endif
    );

    // Expected write: {ADR_O, DAT_O, dcx, WE_O}
    typedef logic [17:0] exp_t;
    exp_t exp_q[$];

    int  checks = 0;
    int  errors = 0;
    int  acks   = 0;
    int  rty_len = 20;
    bit  ack_hold = 1'b0;
    logic prev_dcx = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave: ACK one cycle after STB, then RTY high for rty_len cycles (0 = never busy).
    initial begin
        int r;
        ACK_I = 1'b0;
        RTY_I = 1'b0;
        forever begin
            @(posedge CLK_I); #1;
            if (STB_O && !ack_hold && RST_I) begin
                ACK_I = 1'b1;
                r = rty_len;
                @(posedge CLK_I); #1;
                ACK_I = 1'b0;
                if (r > 0) begin
                    RTY_I = 1'b1;
                    repeat (r) @(posedge CLK_I);
                    #1;
                    RTY_I = 1'b0;
                end
            end
        end
    end

    always @(negedge CLK_I) begin
        exp_t e;
        if (RST_I) begin
            if (STB_O) begin
                checks++;
                if (RTY_I) begin
                    errors++;
                    $display("FAIL stb_while_rty: got STB_O=1 with RTY_I=1 expected STB_O=0");
                end
            end
            if (STB_O && ACK_I) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got adr 0x%0h dat 0x%0h expected no write", ADR_O, DAT_O);
                end else begin
                    e = exp_q.pop_front();
                    check("write", {14'd0, ADR_O, DAT_O, dcx, WE_O}, {14'd0, e});
                end
                acks++;
            end
            if (dcx !== prev_dcx) begin
                checks++;
                if (RTY_I) begin
                    errors++;
                    $display("FAIL dcx_change_busy: got dcx change with RTY_I=1 expected RTY_I=0");
                end
            end
        end
        prev_dcx = dcx;
    end

    task automatic send(input logic [7:0] d, input logic dc, input logic last);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_dc = dc; in_last = last;
        @(negedge CLK_I);
        while (!in_ready && n < 3000) begin @(negedge CLK_I); n++; end
        if (!in_ready) begin
            check("send_timeout", 32'd1, 32'd0);
        end else begin
            exp_q.push_back({~last, 7'd0, d, dc, 1'b1});
        end
        @(posedge CLK_I); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 8000) begin @(posedge CLK_I); #1; n++; end
        check("drain_pending", busy + exp_q.size(), 32'd0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 500) begin @(posedge CLK_I); #1; n++; end
        check("ready_timeout", in_ready, 1'b1);
    endtask

    task automatic count_resetn_low(input string name);
        int n = 0;
        while (lcd_resetn && n < 500) begin @(posedge CLK_I); #1; n++; end
        n = 0;
        while (!lcd_resetn && n < 500) begin @(posedge CLK_I); #1; n++; end
        check(name, n, 32'd16);
    endtask

    initial begin
        int n;
        int a0;
        int acc;
        int low;
        bit stb_seen;
        RST_I = 1'b0; soft_reset = 1'b0; in_valid = 1'b0;
        in_data = 8'h00; in_dc = 1'b0; in_last = 1'b0;
        repeat (3) @(posedge CLK_I);
        #1;
        check("rst_stb", STB_O, 1'b0);
        check("rst_we", WE_O, 1'b0);
        check("rst_adr", ADR_O, 8'h00);
        check("rst_dat", DAT_O, 8'h00);
        check("rst_dcx", dcx, 1'b1);
        check("rst_resetn", lcd_resetn, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b1);

        RST_I = 1'b1;
        stb_seen = 1'b0;
        n = 0;
        while (!lcd_resetn && n < 200) begin @(posedge CLK_I); #1; n++; stb_seen |= STB_O; end
        check("resetn_low_cycles", n, 32'd16);
        n = 0;
        while (!in_ready && n < 500) begin @(posedge CLK_I); #1; n++; stb_seen |= STB_O; end
        check("wait_cycles", n, 32'd64);
        check("stb_during_reset", stb_seen, 1'b0);
        check("idle_busy", busy, 1'b0);

        // CASET-style burst
        rty_len = 20;
        a0 = acks;
        send(8'h2A, 1'b0, 1'b0);
        send(8'h00, 1'b1, 1'b0);
        send(8'hEF, 1'b1, 1'b1);
        drain();
        check("burst_writes", acks - a0, 32'd3);

        // FIFO fills while slave is stalled
        rty_len = 200;
        send(8'hC0, 1'b1, 1'b1);
        n = 0;
        while (!RTY_I && n < 50) begin @(posedge CLK_I); #1; n++; end
        check("stall_started", RTY_I, 1'b1);
        rty_len = 3;
        acc = 0; low = 0; n = 0;
        in_valid = 1'b1; in_data = 8'($urandom); in_dc = 1'b1; in_last = 1'b0;
        while (low < 10 && n < 100) begin
            @(negedge CLK_I);
            n++;
            if (in_ready) begin
                acc++;
                low = 0;
                exp_q.push_back({~in_last, 7'd0, in_data, in_dc, 1'b1});
                @(posedge CLK_I); #1;
                in_data = 8'($urandom); in_dc = 1'($urandom); in_last = 1'($urandom);
            end else begin
                low++;
            end
        end
        in_valid = 1'b0;
        check("fill_count", acc, 32'd8);
        drain();

        // Randomized traffic, including slaves that never raise RTY_I
        a0 = acks;
        for (int i = 0; i < 40; i++) begin
            rty_len = $urandom_range(0, 25);
            send(8'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 30)) @(posedge CLK_I);
            #0;
        end
        drain();
        check("random_writes", acks - a0, 32'd40);

        // soft_reset while the 0x11 byte sits in WAIT_IDLE
        rty_len = 30;
        a0 = acks;
        send(8'h11, 1'b1, 1'b1);
        n = 0;
        while (!RTY_I && n < 50) begin @(posedge CLK_I); #1; n++; end
        @(posedge CLK_I); #1;
        send(8'h21, 1'b1, 1'b0);
        send(8'h22, 1'b1, 1'b0);
        send(8'h23, 1'b1, 1'b1);
        soft_reset = 1'b1;
        @(posedge CLK_I); #1;
        soft_reset = 1'b0;
        exp_q.delete();
        count_resetn_low("soft_resetn_low_cycles");
        wait_ready();
        check("soft_fifo_empty", busy, 1'b0);
        check("soft_writes", acks - a0, 32'd1);

        // Asynchronous reset during ISSUE
        ack_hold = 1'b1;
        rty_len = 5;
        send(8'h55, 1'b0, 1'b1);
        n = 0;
        while (!STB_O && n < 50) begin @(posedge CLK_I); #1; n++; end
        check("issue_reached", STB_O, 1'b1);
        #2;
        RST_I = 1'b0;
        #1;
        check("async_stb", STB_O, 1'b0);
        check("async_we", WE_O, 1'b0);
        check("async_resetn", lcd_resetn, 1'b0);
        check("async_dcx", dcx, 1'b1);
        exp_q.delete();
        @(posedge CLK_I); #1;
        ack_hold = 1'b0;
        RST_I = 1'b1;
        wait_ready();

`ifdef ILI_SEQ_BYTE_COUNT_EN
        check("count_after_reset", bytes_sent, 16'd0);
        rty_len = 4;
        for (int i = 0; i < 5; i++) send(8'($urandom), 1'b1, (i == 4) ? 1'b1 : 1'b0);
        drain();
        check("bytes_sent_5", bytes_sent, 16'd5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
